// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB link constants and FSM state type
package apb_pkg;
  localparam int APB_ADDR_W = 7;
  localparam int APB_DATA_W = 32;
  localparam int APB_WAIT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;
endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - ACCESS wait-state counter with timeout detection
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);
  logic [APB_WAIT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Flags the not-ready cycle whose closing edge brings the count to TIMEOUT.
  assign o_expired = i_en && (r_count == APB_WAIT_W'(TIMEOUT - 1));
endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB initiator: command handshake in, SETUP/ACCESS out, one response per command
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_res,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_rsp_timeout,
  output logic [ADDR_W-1:0] o_paddr,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);
  apb_state_t        r_state;
  apb_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_pwrite;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;
  logic              w_done;
  logic              w_accept;
  logic              w_expired;

  assign w_done      = (r_state == ACCESS) && i_pready;
  assign o_cmd_ready = !i_res && ((r_state == IDLE) || w_done);
  assign w_accept    = i_cmd_valid && o_cmd_ready;

  // Decoded from the asynchronously reset state so reset drops the bus without a clock.
  assign o_psel    = (r_state != IDLE);
  assign o_penable = (r_state == ACCESS);

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .i_clk    (i_clk),
    .i_rst    (i_res),
    .i_clear  (r_state == SETUP),
    .i_en     ((r_state == ACCESS) && !i_pready),
    .o_expired(w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS: begin
        if (w_done) begin
          w_state_nxt = w_accept ? SETUP : IDLE;
        end else if (w_expired) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      r_state  <= IDLE;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_paddr  <= i_cmd_addr;
        r_pwrite <= i_cmd_write;
        r_pwdata <= i_cmd_wdata;
      end
    end
  end

  // Errored reads return zero data so callers never consume a half-valid word.
  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid   <= w_done || w_expired;
      r_rsp_rdata   <= (w_done && !r_pwrite && !i_pslverr) ? i_prdata : '0;
      r_rsp_err     <= (w_done && i_pslverr) || w_expired;
      r_rsp_timeout <= w_expired;
    end
  end

  assign o_paddr       = r_paddr;
  assign o_pwrite      = r_pwrite;
  assign o_pwdata      = r_pwdata;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_err     = r_rsp_err;
  assign o_rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - randomized bench for apb_master against a per-cycle transaction timeline model
module tb_apb_master;
  localparam int T    = 16;
  localparam int MAXC = 3000;

  logic        clk = 1'b0;
  logic        res;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [6:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  always #5 clk = ~clk;

  apb_master #(.ADDR_W(7), .DATA_W(32), .TIMEOUT(T)) dut (
    .i_clk(clk), .i_res(res),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_rsp_timeout(rsp_timeout),
    .o_paddr(paddr), .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite),
    .o_pwdata(pwdata), .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
  );

  // Stimulus per cycle
  logic        drv_valid [MAXC];
  logic        drv_write [MAXC];
  logic [6:0]  drv_addr  [MAXC];
  logic [31:0] drv_wdata [MAXC];
  logic        drv_pready[MAXC];
  logic [31:0] drv_prdata[MAXC];
  logic        drv_pslverr[MAXC];
  // Expected outputs per cycle
  logic        exp_ready [MAXC];
  logic        exp_psel  [MAXC];
  logic        exp_pen   [MAXC];
  logic        bus_set   [MAXC];
  logic [6:0]  exp_paddr [MAXC];
  logic        exp_pwrite[MAXC];
  logic [31:0] exp_pwdata[MAXC];
  logic        exp_rv    [MAXC];
  logic [31:0] exp_rdata [MAXC];
  logic        exp_err   [MAXC];
  logic        exp_to    [MAXC];

  int n_cmp = 0;
  int n_err = 0;
  int free_c;
  int n_cyc;

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // One command presented 'gap' cycles after the master can first take it, with w wait states.
  task automatic add_txn(input int gap, input logic wr, input logic [6:0] addr, input logic [31:0] wd,
                         input int w, input logic [31:0] rd, input logic se);
    int a, nacc, c, fin;
    a = free_c + gap;
    drv_valid[a] = 1'b1; drv_write[a] = wr; drv_addr[a] = addr; drv_wdata[a] = wd;
    exp_ready[a+1] = 1'b0; exp_psel[a+1] = 1'b1; exp_pen[a+1] = 1'b0;
    nacc = (w < T) ? w + 1 : T;
    for (int k = -1; k < nacc; k++) begin
      c = a + 2 + k;
      bus_set[c] = 1'b1; exp_paddr[c] = addr; exp_pwrite[c] = wr; exp_pwdata[c] = wd;
    end
    for (int k = 0; k < nacc; k++) begin
      c = a + 2 + k;
      exp_psel[c] = 1'b1; exp_pen[c] = 1'b1; exp_ready[c] = 1'b0; drv_pready[c] = 1'b0;
    end
    if (w < T) begin
      fin = a + 2 + w;
      drv_pready[fin] = 1'b1; drv_prdata[fin] = rd; drv_pslverr[fin] = se;
      exp_ready[fin] = 1'b1;
      exp_rv[fin+1] = 1'b1; exp_rdata[fin+1] = (!wr && !se) ? rd : 32'h0;
      exp_err[fin+1] = se; exp_to[fin+1] = 1'b0;
      free_c = fin;
    end else begin
      fin = a + 1 + T;
      exp_rv[fin+1] = 1'b1; exp_rdata[fin+1] = 32'h0; exp_err[fin+1] = 1'b1; exp_to[fin+1] = 1'b1;
      free_c = fin + 1;
    end
  endtask

  task automatic build_plan();
    int ntx, r, w;
    logic [6:0]  la;
    logic        lw;
    logic [31:0] ld;
    for (int c = 0; c < MAXC; c++) begin
      drv_valid[c] = 1'b0; drv_write[c] = 1'($urandom); drv_addr[c] = 7'($urandom);
      drv_wdata[c] = $urandom; drv_pready[c] = 1'($urandom); drv_prdata[c] = $urandom;
      drv_pslverr[c] = 1'($urandom);
      exp_ready[c] = 1'b1; exp_psel[c] = 1'b0; exp_pen[c] = 1'b0; bus_set[c] = 1'b0;
      exp_paddr[c] = 7'h0; exp_pwrite[c] = 1'b0; exp_pwdata[c] = 32'h0;
      exp_rv[c] = 1'b0; exp_rdata[c] = 32'h0; exp_err[c] = 1'b0; exp_to[c] = 1'b0;
    end
    free_c = 0;
    add_txn(1, 1'b1, 7'h05, 32'hDEADBEEF, 0, $urandom, 1'b0);
    add_txn(2, 1'b0, 7'h10, $urandom, 3, 32'h12345678, 1'b0);
    add_txn(0, 1'b1, 7'h21, 32'h11112222, 0, $urandom, 1'b0);
    add_txn(0, 1'b1, 7'h22, 32'h33334444, 0, $urandom, 1'b0);
    add_txn(1, 1'b0, 7'h30, $urandom, 1, 32'hCAFEF00D, 1'b1);
    add_txn(0, 1'b0, 7'h40, $urandom, T, $urandom, 1'b0);
    add_txn(0, 1'b1, 7'h41, 32'h0BADC0DE, T - 1, $urandom, 1'b0);
    ntx = 0;
    while (ntx < 70 && free_c < MAXC - 100) begin
      r = int'($urandom_range(0, 7));
      if (r <= 4)      w = r;
      else if (r == 5) w = T;
      else if (r == 6) w = T - 1;
      else             w = int'($urandom_range(0, 2));
      add_txn(int'($urandom_range(0, 3)), 1'($urandom), 7'($urandom), $urandom, w, $urandom, 1'($urandom));
      ntx++;
    end
    n_cyc = free_c + 6;
    // Offer junk commands whenever the master must not accept; it has to ignore them.
    for (int c = 0; c < n_cyc; c++)
      if (!exp_ready[c]) drv_valid[c] = 1'($urandom);
    la = 7'h0; lw = 1'b0; ld = 32'h0;
    for (int c = 0; c < n_cyc; c++) begin
      if (bus_set[c]) begin
        la = exp_paddr[c]; lw = exp_pwrite[c]; ld = exp_pwdata[c];
      end else begin
        exp_paddr[c] = la; exp_pwrite[c] = lw; exp_pwdata[c] = ld;
      end
    end
  endtask

  task automatic check_cycle(input int c);
    chk("cmd_ready", c, 32'(cmd_ready), 32'(exp_ready[c]));
    chk("psel", c, 32'(psel), 32'(exp_psel[c]));
    chk("penable", c, 32'(penable), 32'(exp_pen[c]));
    chk("paddr", c, 32'(paddr), 32'(exp_paddr[c]));
    chk("pwrite", c, 32'(pwrite), 32'(exp_pwrite[c]));
    chk("pwdata", c, pwdata, exp_pwdata[c]);
    chk("rsp_valid", c, 32'(rsp_valid), 32'(exp_rv[c]));
    if (exp_rv[c]) begin
      chk("rsp_rdata", c, rsp_rdata, exp_rdata[c]);
      chk("rsp_err", c, 32'(rsp_err), 32'(exp_err[c]));
      chk("rsp_timeout", c, 32'(rsp_timeout), 32'(exp_to[c]));
    end
    case (c)
      2:  begin chk("lit_wdata", c, pwdata, 32'hDEADBEEF); chk("lit_setup_pen", c, 32'(penable), 32'h0); end
      4:  begin chk("lit_wr_rsp", c, 32'(rsp_valid), 32'h1); chk("lit_wr_err", c, 32'(rsp_err), 32'h0); end
      6, 10: chk("lit_rd_paddr", c, 32'(paddr), 32'h10);
      11: begin chk("lit_rd_rsp", c, 32'(rsp_valid), 32'h1); chk("lit_rd_data", c, rsp_rdata, 32'h12345678); end
      12, 14: chk("lit_b2b_psel", c, 32'(psel), 32'h1);
      13, 15: chk("lit_b2b_rsp", c, 32'(rsp_valid), 32'h1);
      19: begin
        chk("lit_slverr_err", c, 32'(rsp_err), 32'h1);
        chk("lit_slverr_to", c, 32'(rsp_timeout), 32'h0);
        chk("lit_slverr_data", c, rsp_rdata, 32'h0);
      end
      35: chk("lit_to_last_access", c, 32'(penable), 32'h1);
      36: begin
        chk("lit_to_psel", c, 32'(psel), 32'h0);
        chk("lit_to_err", c, 32'(rsp_err), 32'h1);
        chk("lit_to_flag", c, 32'(rsp_timeout), 32'h1);
      end
      54: begin chk("lit_late_rsp", c, 32'(rsp_valid), 32'h1); chk("lit_late_to", c, 32'(rsp_timeout), 32'h0); end
      default: ;
    endcase
  endtask

  initial begin
    res = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 7'h0; cmd_wdata = 32'h0;
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    build_plan();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cmd_ready", -1, 32'(cmd_ready), 32'h0);
    chk("rst_psel", -1, 32'(psel), 32'h0);
    chk("rst_penable", -1, 32'(penable), 32'h0);
    chk("rst_paddr", -1, 32'(paddr), 32'h0);
    chk("rst_pwdata", -1, pwdata, 32'h0);
    chk("rst_rsp_valid", -1, 32'(rsp_valid), 32'h0);
    @(negedge clk);
    res = 1'b0;
    fork
      begin
        for (int c = 0; c < n_cyc; c++) begin
          @(posedge clk); #1;
          cmd_valid = drv_valid[c]; cmd_write = drv_write[c]; cmd_addr = drv_addr[c];
          cmd_wdata = drv_wdata[c]; pready = drv_pready[c]; prdata = drv_prdata[c];
          pslverr = drv_pslverr[c];
        end
      end
      begin
        for (int c = 0; c < n_cyc; c++) begin
          @(posedge clk); @(negedge clk);
          check_cycle(c);
        end
      end
    join

    // Asynchronous reset in the middle of a wait state
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h22; pready = 1'b0; pslverr = 1'b0;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("ar_pre_penable", -2, 32'(penable), 32'h1);
    res = 1'b1; #1;
    chk("ar_psel", -2, 32'(psel), 32'h0);
    chk("ar_penable", -2, 32'(penable), 32'h0);
    chk("ar_cmd_ready", -2, 32'(cmd_ready), 32'h0);
    chk("ar_rsp_valid", -2, 32'(rsp_valid), 32'h0);
    chk("ar_paddr", -2, 32'(paddr), 32'h0);
    @(posedge clk); #3;
    res = 1'b0; pready = 1'b1; #1;
    chk("ar_rel_ready", -2, 32'(cmd_ready), 32'h1);
    chk("ar_rel_rsp", -2, 32'(rsp_valid), 32'h0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h33; cmd_wdata = 32'hA5A5F00D;
    @(posedge clk); #1; cmd_valid = 1'b0; #1;
    chk("ar_setup_psel", -2, 32'(psel), 32'h1);
    chk("ar_setup_pen", -2, 32'(penable), 32'h0);
    chk("ar_setup_wdata", -2, pwdata, 32'hA5A5F00D);
    chk("ar_setup_rsp", -2, 32'(rsp_valid), 32'h0);
    @(posedge clk); #2;
    chk("ar_access_pen", -2, 32'(penable), 32'h1);
    chk("ar_access_rsp", -2, 32'(rsp_valid), 32'h0);
    @(posedge clk); #2;
    chk("ar_rsp_valid_new", -2, 32'(rsp_valid), 32'h1);
    chk("ar_rsp_err_new", -2, 32'(rsp_err), 32'h0);
    chk("ar_idle_psel", -2, 32'(psel), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
